// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register file writeback arbiter.
package regfile_wb_arbiter_pkg;

  // Width of the pending-write scoreboard (one bit per architectural register).
  localparam int unsigned REGS = 32;

  // Index of the hard-wired zero register.
  localparam int unsigned R0_IDX = 0;

  // Default widths.
  localparam int unsigned NREQ_DEF = 3;
  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned AW_DEF   = 5;

  // Pointer advance after a grant to index g: wraps to 0 past the last requester.
  function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin priority scan: first valid request at or after ptr, modulo NREQ.
module rr_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx,
  output logic            gnt_any
);

  int unsigned     idx;
  logic [PW-1:0]   idx_w;

  // Scan from the pointer and take the first valid requester.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    idx_w   = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx   = (32'(ptr) + off) % NREQ;
      idx_w = PW'(idx);
      if (!gnt_any && req[idx_w]) begin
        gnt_any    = 1'b1;
        gnt_idx    = idx_w;
        gnt[idx_w] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter with registered write outputs and a
// pending-write scoreboard for issue-stage operand stalls.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned AW   = AW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               rsv_valid,
  input  logic [AW-1:0]      rsv_addr,
  output logic               we3,
  output logic [AW-1:0]      wa3,
  output logic [DW-1:0]      wd3,
  output logic [REGS-1:0]    pend
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q;
  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic [REGS-1:0] pend_q, pend_d;

  logic [AW-1:0] addr_arr [NREQ];
  logic [DW-1:0] data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*AW +: AW];
    assign data_arr[i] = req_data[i*DW +: DW];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Grant is suppressed while reset is held so no transfer can be counted.
  assign req_ready = rst_n ? gnt : '0;
  assign xfer      = rst_n && gnt_any;
  assign sel_addr  = addr_arr[gnt_idx];
  assign sel_data  = data_arr[gnt_idx];

  // Pointer moves past the winner on a transfer, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (xfer) begin
      ptr_q <= PW'(rr_next(32'(gnt_idx), NREQ));
    end
  end

  // Register the winning write; r0 completes the handshake but never writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else begin
      we3 <= xfer && (sel_addr != AW'(R0_IDX));
      if (xfer) begin
        wa3 <= sel_addr;
        wd3 <= sel_data;
      end
    end
  end

  // Scoreboard next state: a new reservation beats the landing write's clear.
  always_comb begin
    pend_d = '0;
    for (int unsigned r = 1; r < REGS; r++) begin
      pend_d[r] = (rsv_valid && (rsv_addr == AW'(r))) ||
                  (pend_q[r] && !(we3 && (wa3 == AW'(r))));
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single write port (we3/wa3/wd3) of the 32x32 three-ported register file among NREQ writeback requesters (ALU, load unit, multiply/divide unit) using round-robin arbitration and a valid/ready handshake. It also keeps a 32-bit pending-write scoreboard so issue logic can stall on operands whose writeback has not landed. The block sits between the execute/memory stages and the register file. All of its outputs are registered, so they are stable before the register file's falling-edge write.

## Interface
- NREQ, 3: number of writeback requesters (2..4).
- DW, 32: write data width.
- AW, 5: register address width.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  requester i holds a write.
- req_addr  in  NREQ*AW  destination of requester i, in slice [i*AW +: AW].
- req_data  in  NREQ*DW  data of requester i, in slice [i*DW +: DW].
- req_ready  out  NREQ  one-hot grant, combinational from req_valid and the pointer.
- rsv_valid  in  1  issue stage reserves a destination this cycle.
- rsv_addr  in  AW  destination being reserved.
- we3  out  1  register file write enable, registered.
- wa3  out  AW  register file write address, registered.
- wd3  out  DW  register file write data, registered.
- pend  out  32  scoreboard; bit r=1 means a write to r is outstanding.

## Operation
- Handshake: a transfer happens on a rising edge where req_valid[i] and req_ready[i] are both 1.
  - After asserting valid, requester i holds req_valid, req_addr and req_data stable until that transfer.
  - At most one req_ready bit is high per cycle. It is never high unless the matching req_valid is high.
- Round-robin arbitration:
  - State is a pointer ptr in 0..NREQ-1, where ptr is the highest-priority index.
  - Grant goes to the first valid requester scanning ptr, ptr+1, ... modulo NREQ.
  - After a transfer by requester g, ptr becomes (g+1) mod NREQ. If there is no transfer, ptr holds.
- Output register, on every edge:
  - we3 <= transfer and addr != 0.
  - wa3/wd3 <= granted addr/data. They hold their previous value when there is no transfer.
  - A write to r0 completes its handshake but is dropped (we3=0).
- Scoreboard, per bit r (r=1..31):
  - Set at the edge where rsv_valid=1 and rsv_addr=r.
  - Cleared at the edge where the registered we3=1 and wa3=r.
  - Simultaneous set and clear of the same r: set wins, because the reservation is newer.
  - pend[0] is constant 0. A reservation of r0 is ignored.
- A write to a register whose pend bit is 0 is legal. It still clears nothing.

## Timing
- Reset (rst_n=0, asynchronous): we3=0, wa3=0, wd3=0, pend=0, ptr=0. req_ready is forced to 0 while rst_n=0.
- Latency, for a transfer at rising edge n:
  - we3/wa3/wd3 are valid during cycle n..n+1.
  - The register file writes at the falling edge inside that cycle. Combinational reads see the new value from that falling edge on.
  - pend clears at edge n+1.
- Throughput: one write per cycle, sustained. A requester that is continuously valid is granted at least once every NREQ cycles.
- Reset mid-operation: all in-flight grants and pend bits are discarded. Requesters must re-present after reset is released.
- req_ready may toggle in the same cycle that req_valid rises. No combinational path exists from req_data to any output.

## Structure
- Shared package holds the scoreboard width constant REGS=32, the r0 index constant, and the default widths NREQ/DW/AW.
- One sub-module is natural: rr_arbiter. It takes NREQ-bit requests and the pointer, and produces a one-hot grant plus the grant index.
- Everything else lives in regfile_wb_arbiter: output register, pointer update, scoreboard.

## Test plan
- Reset, then a single request: req0 valid, addr=5, data=0xDEADBEEF.
  - req_ready[0]=1 in that cycle. Next cycle we3=1, wa3=5, wd3=0xDEADBEEF.
  - A regfile read of r5 returns 0xDEADBEEF after the falling edge.
- All three requesters valid continuously with distinct addresses 1/2/3.
  - Grants go 0,1,2,0,1,2 on consecutive cycles. we3 stays 1 every cycle after the first.
- Write to r0: req1 valid, addr=0, data=0x1234.
  - Handshake completes and we3 stays 0. ptr advances to 2.
- Scoreboard set/clear:
  - rsv r7 → pend[7]=1.
  - req2 writes r7 → pend[7]=0 one edge after the we3 cycle.
  - Reserve r9 in the same cycle that we3 writes r9 → pend[9] stays 1.
- Reset mid-operation: pend=0x000000F0, we3=1, then rst_n dropped asynchronously mid-cycle.
  - we3, wa3, wd3 and pend go to 0 immediately. After release, the first grant goes to req0.
